// File: rtl/pipe_stall_ctrl.sv
// Stall merger and multi-cycle EX sequencer for the five-stage core.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int MC_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        mc_start,
    input  logic        stallreq_mem,
    input  logic        flush,
    output logic [5:0]  stall,
    output logic        mc_done,
    output logic        mc_busy,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_mc_ops,
    output logic [31:0] perf_load_use
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD    = 8'(MC_CYCLES - 1);
    localparam logic [5:0] STALL_MEM   = 6'b011111;
    localparam logic [5:0] STALL_EX    = 6'b001111;
    localparam logic [5:0] STALL_ID    = 6'b000111;

    state_t     state;
    logic [7:0] cnt;
    logic       stallreq_ex;

    // EX asks for a hold from the start cycle through the last BUSY cycle.
    always_comb begin
        stallreq_ex = ((state == IDLE) && mc_start) || (state == BUSY);
    end

    always_comb begin
        stall = 6'b000000;
        if (rst || flush)
            stall = 6'b000000;
        else if (stallreq_mem)
            stall = STALL_MEM;
        else if (stallreq_ex)
            stall = STALL_EX;
        else if (stallreq_id)
            stall = STALL_ID;
    end

    always_comb begin
        mc_done = !rst && !flush && (state == DONE);
        mc_busy = !rst && ((state == BUSY) || (state == DONE));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    // Memory wait states do not pause the divider.
                    if (cnt == 8'd0)
                        state <= DONE;
                    else
                        cnt <= cnt - 8'd1;
                end
                DONE: begin
                    // Result slot is held until EX can actually advance.
                    if (!stallreq_mem)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] stall_cyc_q;
    logic [31:0] mc_ops_q;
    logic [31:0] load_use_q;
    logic        mc_exit;

    always_comb begin
        mc_exit = (state == DONE) && !stallreq_mem && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_q <= 32'd0;
            mc_ops_q    <= 32'd0;
            load_use_q  <= 32'd0;
        end else begin
            if (stall[0])
                stall_cyc_q <= stall_cyc_q + 32'd1;
            if (mc_exit)
                mc_ops_q <= mc_ops_q + 32'd1;
            if (stall == STALL_ID)
                load_use_q <= load_use_q + 32'd1;
        end
    end

    always_comb begin
        perf_stall_cyc = rst ? 32'd0 : stall_cyc_q;
        perf_mc_ops    = rst ? 32'd0 : mc_ops_q;
        perf_load_use  = rst ? 32'd0 : load_use_q;
    end
`else
    always_comb begin
        perf_stall_cyc = 32'd0;
        perf_mc_ops    = 32'd0;
        perf_load_use  = 32'd0;
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MC_CYCLES=4; perf expectations
// collapse to zero unless STALL_PERF_EN is defined.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        mc_start;
    logic        stallreq_mem;
    logic        flush;
    logic [5:0]  stall;
    logic        mc_done;
    logic        mc_busy;
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_mc_ops;
    logic [31:0] perf_load_use;

    int errors = 0;
    int checks = 0;

    pipe_stall_ctrl #(.MC_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .mc_start       (mc_start),
        .stallreq_mem   (stallreq_mem),
        .flush          (flush),
        .stall          (stall),
        .mc_done        (mc_done),
        .mc_busy        (mc_busy),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_mc_ops    (perf_mc_ops),
        .perf_load_use  (perf_load_use)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pf(input int n);
`ifdef STALL_PERF_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic drive(input logic id, input logic st, input logic mem, input logic fl);
        stallreq_id  = id;
        mc_start     = st;
        stallreq_mem = mem;
        flush        = fl;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        settle();
        checks++;
        if ({stall, mc_done, mc_busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b done=%b busy=%b, want 0", stall, mc_done, mc_busy);
        end
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if ({stall, mc_done, mc_busy} !== 8'h00 || perf_stall_cyc !== 32'd0 ||
            perf_mc_ops !== 32'd0 || perf_load_use !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle: got stall=%b done=%b busy=%b perf=%0d/%0d/%0d, want all 0",
                     stall, mc_done, mc_busy, perf_stall_cyc, perf_mc_ops, perf_load_use);
        end
        next_cycle();
    endtask

    task automatic test_load_use;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (stall !== 6'b000111) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 000111", stall);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (stall !== 6'b000000 || perf_load_use !== pf(1) || perf_stall_cyc !== pf(1)) begin
            errors++;
            $display("FAIL load_use_after: got stall=%b lu=%0d sc=%0d want 000000 lu=%0d sc=%0d",
                     stall, perf_load_use, perf_stall_cyc, pf(1), pf(1));
        end
        next_cycle();
    endtask

    // mc_start stays high through DONE to show it is ignored there.
    task automatic test_divide;
        for (int c = 0; c <= 6; c++) begin
            drive(1'b0, (c <= 5), 1'b0, 1'b0);
            settle();
            checks++;
            if (c <= 4) begin
                if (stall !== 6'b001111 || mc_done !== 1'b0 || mc_busy !== (c != 0)) begin
                    errors++;
                    $display("FAIL divide_c%0d: got stall=%b done=%b busy=%b want 001111 0 %b",
                             c, stall, mc_done, mc_busy, (c != 0));
                end
            end else if (c == 5) begin
                if (stall !== 6'b000000 || mc_done !== 1'b1 || mc_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL divide_done: got stall=%b done=%b busy=%b want 000000 1 1",
                             stall, mc_done, mc_busy);
                end
            end else begin
                if (stall !== 6'b000000 || mc_done !== 1'b0 || mc_busy !== 1'b0 ||
                    perf_mc_ops !== pf(1) || perf_stall_cyc !== pf(6)) begin
                    errors++;
                    $display("FAIL divide_idle: got stall=%b done=%b busy=%b ops=%0d sc=%0d want 0 0 0 %0d %0d",
                             stall, mc_done, mc_busy, perf_mc_ops, perf_stall_cyc, pf(1), pf(6));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait_done;
        logic [5:0] exp_stall;
        logic       exp_done;
        for (int c = 0; c <= 8; c++) begin
            drive(1'b0, (c == 0), (c == 5 || c == 6), 1'b0);
            exp_stall = (c <= 4) ? 6'b001111 : (c <= 6) ? 6'b011111 : 6'b000000;
            exp_done  = (c >= 5 && c <= 7);
            settle();
            checks++;
            if (stall !== exp_stall || mc_done !== exp_done) begin
                errors++;
                $display("FAIL memwait_c%0d: got stall=%b done=%b want %b %b",
                         c, stall, mc_done, exp_stall, exp_done);
            end
            next_cycle();
        end
        settle();
        checks++;
        if (mc_busy !== 1'b0 || perf_mc_ops !== pf(2) || perf_stall_cyc !== pf(13)) begin
            errors++;
            $display("FAIL memwait_end: got busy=%b ops=%0d sc=%0d want 0 %0d %0d",
                     mc_busy, perf_mc_ops, perf_stall_cyc, pf(2), pf(13));
        end
    endtask

    task automatic test_flush;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++;
        if (stall !== 6'b000000 || mc_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got stall=%b done=%b want 000000 0", stall, mc_done);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            settle();
            checks++;
            if (mc_done !== 1'b0 || mc_busy !== 1'b0 || stall !== 6'b000000) begin
                errors++;
                $display("FAIL flush_after_c%0d: got done=%b busy=%b stall=%b want 0 0 000000",
                         c, mc_done, mc_busy, stall);
            end
            next_cycle();
        end
        settle();
        checks++;
        if (perf_mc_ops !== pf(2) || perf_stall_cyc !== pf(15)) begin
            errors++;
            $display("FAIL flush_perf: got ops=%0d sc=%0d want %0d %0d",
                     perf_mc_ops, perf_stall_cyc, pf(2), pf(15));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        checks++;
        if (stall !== 6'b000000) begin
            errors++;
            $display("FAIL flush_vs_start: got stall=%b want 000000", stall);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (mc_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_start_state: got busy=%b want 0", mc_busy);
        end
        next_cycle();
    endtask

    task automatic test_priority;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        checks++;
        if (stall !== 6'b011111) begin
            errors++;
            $display("FAIL priority_all: got %b want 011111", stall);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (mc_busy !== 1'b1 || stall !== 6'b001111) begin
            errors++;
            $display("FAIL priority_busy: got busy=%b stall=%b want 1 001111", mc_busy, stall);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (stall !== 6'b001111) begin
            errors++;
            $display("FAIL ex_beats_id: got %b want 001111", stall);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++;
        if (perf_load_use !== pf(1) || perf_stall_cyc !== pf(18)) begin
            errors++;
            $display("FAIL priority_perf: got lu=%0d sc=%0d want %0d %0d",
                     perf_load_use, perf_stall_cyc, pf(1), pf(18));
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // A 32-cycle-style op is aborted by reset while still BUSY.
    task automatic test_reset_mid_op;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        checks++;
        if ({stall, mc_done, mc_busy} !== 8'h00 || perf_stall_cyc !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_during: got stall=%b done=%b busy=%b sc=%0d want all 0",
                     stall, mc_done, mc_busy, perf_stall_cyc);
        end
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            settle();
            checks++;
            if ({stall, mc_done, mc_busy} !== 8'h00 || perf_stall_cyc !== 32'd0 ||
                perf_mc_ops !== 32'd0 || perf_load_use !== 32'd0) begin
                errors++;
                $display("FAIL rst_mid_after_c%0d: got stall=%b done=%b busy=%b perf=%0d/%0d/%0d want all 0",
                         c, stall, mc_done, mc_busy, perf_stall_cyc, perf_mc_ops, perf_load_use);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_load_use();
        test_divide();
        test_mem_wait_done();
        test_flush();
        test_priority();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall and multi-cycle-operation sequencer for the five-stage core. It merges stall requests from decode (load-use), execute (multi-cycle ops such as divide) and memory (wait states) into one per-stage stall vector. It also runs the cycle counter that holds a multi-cycle EX operation in place until its result is ready. It sits beside the pipeline registers, drives their hold inputs, and returns a completion pulse to EX.

## Interface
- MC_CYCLES, default 32: number of BUSY cycles a multi-cycle EX op occupies; legal range 1..255.
- clk  in  1: rising-edge clock.
- rst  in  1: reset, synchronous, active-high.
- stallreq_id  in  1: decode requests a stall (load-use on a forwarded operand).
- mc_start  in  1: EX holds a valid multi-cycle op this cycle.
- stallreq_mem  in  1: memory stage not ready (wait state).
- flush  in  1: pipeline flush (exception or redirect); aborts any multi-cycle op.
- stall  out  6: hold per stage; bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- mc_done  out  1: multi-cycle result valid this cycle; EX may commit.
- mc_busy  out  1: FSM is in BUSY or DONE.
- perf_stall_cyc  out  32: cycles with stall[0]=1 (see Configuration).
- perf_mc_ops  out  32: completed multi-cycle ops.
- perf_load_use  out  32: cycles in which stallreq_id was the winning source.

## Operation
- FSM states:
  - IDLE: no multi-cycle op active.
  - BUSY: counter running.
  - DONE: one-cycle result slot.
- Counter cnt is 8 bits wide.
- IDLE:
  - On mc_start: load cnt=MC_CYCLES-1 and go to BUSY.
  - The EX stall request is asserted in the same cycle, combinationally.
- BUSY:
  - EX stall request is asserted.
  - If cnt==0, go to DONE; otherwise cnt decrements by 1.
  - stallreq_mem does not pause the counter.
- DONE:
  - mc_done=1 and the EX stall request is deasserted.
  - If stallreq_mem=1: stay in DONE with mc_done held at 1, because EX cannot advance.
  - Otherwise return to IDLE.
  - mc_start is ignored in DONE; it still refers to the completing instruction.
- Stall vector priority, highest first:
  - flush=1: stall=6'b000000.
  - MEM request: stall=6'b011111.
  - EX request (IDLE with mc_start, or BUSY): stall=6'b001111.
  - stallreq_id: stall=6'b000111.
  - Otherwise 6'b000000.
- flush (synchronous):
  - Next state is IDLE and cnt=0.
  - mc_done=0 and stall=0 in the flush cycle.
  - flush overrides mc_start in the same cycle.
- mc_busy=1 in BUSY and DONE.

## Timing
- stall and mc_done are combinational from the inputs and the current state.
- State and cnt are registered on the rising edge.
- Multi-cycle latency: start cycle, then MC_CYCLES BUSY cycles, then 1 DONE cycle. The op therefore occupies EX for MC_CYCLES+2 cycles when MEM does not stall.
- MC_CYCLES=1 gives exactly one BUSY cycle.
- Reset values: state IDLE, cnt 0, stall 0, mc_done 0, mc_busy 0, all perf counters 0.
- While rst=1, all outputs are 0 regardless of the other inputs.
- Reset asserted mid-BUSY abandons the op with no mc_done pulse.
- Simultaneous stallreq_id and mc_start in IDLE: stall=6'b001111 (EX wins); perf_load_use does not increment.

## Configuration
- STALL_PERF_EN defined:
  - The three 32-bit counters are implemented and wrap at 2^32.
  - They are cleared only by rst, not by flush.
  - perf_stall_cyc increments when stall[0]=1.
  - perf_mc_ops increments on each cycle DONE exits to IDLE.
  - perf_load_use increments when the final stall equals 6'b000111.
- STALL_PERF_EN undefined: the perf ports stay present and are tied to 0, with no flops implemented.

## Test plan
- Load-use alone: stallreq_id=1 for 1 cycle in IDLE -> stall=6'b000111 that cycle and 0 the next; perf_load_use=1.
- Divide: MC_CYCLES=4, mc_start pulse at cycle 0 ->
  - stall=6'b001111 in cycles 0–4;
  - cycle 5 DONE with mc_done=1 and stall=0;
  - cycle 6 IDLE; perf_mc_ops=1.
- MEM wait in DONE: stallreq_mem=1 in cycles 5–6 of the previous scenario ->
  - stall=6'b011111 in cycles 5–6;
  - mc_done=1 in cycles 5–7;
  - return to IDLE after cycle 7.
- Flush mid-op: flush=1 at cycle 2 of a 4-cycle op -> stall=0 at cycle 2, IDLE at cycle 3, no mc_done, perf_mc_ops unchanged.
- Priority: in IDLE, stallreq_id=1, mc_start=1 and stallreq_mem=1 in the same cycle -> stall=6'b011111; the next state is BUSY.
- Reset: rst=1 at cycle 3 of a 32-cycle op -> the next cycle shows all outputs 0 and IDLE; with STALL_PERF_EN, all counters read 0.
